// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Holds the FSM state encoding, datapath widths and the ALU_32 opcode
// constants ({Shift,Ainvert,Binvert,CarryIn,Op2,Op1,Op0}).
package alu_arbiter_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int OP_W    = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] OP_AND  = 7'b0000000;
  localparam logic [OP_W-1:0] OP_OR   = 7'b0000001;
  localparam logic [OP_W-1:0] OP_ADD  = 7'b0000010;
  localparam logic [OP_W-1:0] OP_SUB  = 7'b0001110;
  localparam logic [OP_W-1:0] OP_SLT  = 7'b0001111;
  localparam logic [OP_W-1:0] OP_NOR  = 7'b0011000;
  localparam logic [OP_W-1:0] OP_NAND = 7'b0011001;
  localparam logic [OP_W-1:0] OP_MUL  = 7'b0100000;
  localparam logic [OP_W-1:0] OP_SLL  = 7'b1000000;
  localparam logic [OP_W-1:0] OP_LOG2 = 7'b1100000;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter.
// master: the client side (drives req and packed operands, sees grant/done/result).
// slave : the arbiter side.
// Packing: requester i owns a_in/b_in[32i+31:32i], h_in[5i+4:5i], op_in[7i+6:7i].
interface alu_arbiter_if #(parameter int N = 4);

  logic [N-1:0]                        req;
  logic [alu_arbiter_pkg::DATA_W*N-1:0]  a_in;
  logic [alu_arbiter_pkg::DATA_W*N-1:0]  b_in;
  logic [alu_arbiter_pkg::SHAMT_W*N-1:0] h_in;
  logic [alu_arbiter_pkg::OP_W*N-1:0]    op_in;
  logic [N-1:0]                        grant;
  logic [N-1:0]                        done;
  logic [alu_arbiter_pkg::DATA_W-1:0]    result;
  logic                                zero;
  logic                                overflow;
  logic                                busy;

  modport master (
    output req, a_in, b_in, h_in, op_in,
    input  grant, done, result, zero, overflow, busy
  );

  modport slave (
    input  req, a_in, b_in, h_in, op_in,
    output grant, done, result, zero, overflow, busy
  );

endinterface

// File: rtl/ALU_32.sv
// 32-bit combinational ALU shared by the arbiter.
// Ports: A, B operands; H shift amount; alu_op opcode;
//        Result, Zero (Result==0), Overflow (signed overflow of ADD/SUB/SLT).
// Unknown opcodes produce Result=0.
module ALU_32
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0]  A,
  input  logic [DATA_W-1:0]  B,
  input  logic [SHAMT_W-1:0] H,
  input  logic [OP_W-1:0]    alu_op,
  output logic [DATA_W-1:0]  Result,
  output logic               Zero,
  output logic               Overflow
);

  logic [DATA_W-1:0]  sum;
  logic [DATA_W-1:0]  diff;
  logic               add_ovf;
  logic               sub_ovf;
  logic [SHAMT_W-1:0] log2_val;

  always_comb begin
    sum      = A + B;
    diff     = A - B;
    add_ovf  = (A[DATA_W-1] == B[DATA_W-1]) && (sum[DATA_W-1] != A[DATA_W-1]);
    sub_ovf  = (A[DATA_W-1] != B[DATA_W-1]) && (diff[DATA_W-1] != A[DATA_W-1]);
    log2_val = '0;
    // Highest set bit of A; A==0 yields 0.
    for (int i = 0; i < DATA_W; i++) begin
      if (A[i]) log2_val = SHAMT_W'(i);
    end

    Result   = '0;
    Overflow = 1'b0;
    case (alu_op)
      OP_AND:  Result = A & B;
      OP_OR:   Result = A | B;
      OP_ADD:  begin Result = sum;  Overflow = add_ovf; end
      OP_SUB:  begin Result = diff; Overflow = sub_ovf; end
      // Sign of the difference corrected by overflow gives the true signed compare.
      OP_SLT:  begin Result = {{(DATA_W-1){1'b0}}, diff[DATA_W-1] ^ sub_ovf}; Overflow = sub_ovf; end
      OP_NOR:  Result = ~(A | B);
      OP_NAND: Result = ~(A & B);
      OP_MUL:  Result = A * B;
      OP_SLL:  Result = B << H;
      OP_LOG2: Result = {{(DATA_W-SHAMT_W){1'b0}}, log2_val};
      default: Result = '0;
    endcase
    Zero = (Result == '0);
  end

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Round-robin picker (combinational).
// Ports: req (N requests), pointer (first index to consider)
//        -> winner_oh (one-hot), winner_idx (binary), found (any request).
// Scan order is pointer, pointer+1, ... wrapping modulo N.
module alu_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  winner_oh,
  output logic [PW-1:0] winner_idx,
  output logic          found
);

  localparam int CW = PW + 1;

  logic [CW-1:0] cand;

  always_comb begin
    found      = 1'b0;
    winner_idx = '0;
    cand       = '0;
    // Walk offsets from the farthest back to the nearest so the closest
    // asserted request to the pointer is the last (winning) assignment.
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, pointer} + CW'(i);
      if (cand >= CW'(N)) cand = cand - CW'(N);
      for (int j = 0; j < N; j++) begin
        if (req[j] && (cand == CW'(j))) begin
          found      = 1'b1;
          winner_idx = PW'(j);
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_oh
    assign winner_oh[gi] = found && (winner_idx == PW'(gi));
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU_32 between N requesters.
// Ports: clk (rising edge), reset (asynchronous, active-low),
//        bus (alu_arbiter_if.slave: req/operands in, grant/done/result/zero/
//        overflow/busy out).
// Flow: IDLE picks a winner and latches its operands, EXEC captures the ALU
// outputs and pulses done, DONE releases the grant. One op per 3 cycles.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  localparam int CW = PW + 1;

  state_t             state_reg;
  logic [N-1:0]       grant_reg;
  logic [N-1:0]       done_reg;
  logic [DATA_W-1:0]  result_reg;
  logic               zero_reg;
  logic               overflow_reg;
  logic               busy_reg;
  logic [PW-1:0]      pointer_reg;
  logic [DATA_W-1:0]  a_reg;
  logic [DATA_W-1:0]  b_reg;
  logic [SHAMT_W-1:0] h_reg;
  logic [OP_W-1:0]    op_reg;

  logic [N-1:0]       winner_oh;
  logic [PW-1:0]      winner_idx;
  logic               found;
  logic [PW-1:0]      pointer_next;
  logic [CW-1:0]      ptr_inc;
  logic [DATA_W-1:0]  a_sel;
  logic [DATA_W-1:0]  b_sel;
  logic [SHAMT_W-1:0] h_sel;
  logic [OP_W-1:0]    op_sel;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_zero;
  logic               alu_overflow;

  alu_arbiter_rr_pick #(.N(N), .PW(PW)) u_pick (
    .req        (bus.req),
    .pointer    (pointer_reg),
    .winner_oh  (winner_oh),
    .winner_idx (winner_idx),
    .found      (found)
  );

  // Operand mux driven by the one-hot winner.
  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    h_sel  = '0;
    op_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (winner_oh[i]) begin
        a_sel  = bus.a_in[DATA_W*i +: DATA_W];
        b_sel  = bus.b_in[DATA_W*i +: DATA_W];
        h_sel  = bus.h_in[SHAMT_W*i +: SHAMT_W];
        op_sel = bus.op_in[OP_W*i +: OP_W];
      end
    end
  end

  always_comb begin
    ptr_inc      = {1'b0, winner_idx} + CW'(1);
    pointer_next = (ptr_inc >= CW'(N)) ? '0 : ptr_inc[PW-1:0];
  end

  ALU_32 u_alu (
    .A        (a_reg),
    .B        (b_reg),
    .H        (h_reg),
    .alu_op   (op_reg),
    .Result   (alu_result),
    .Zero     (alu_zero),
    .Overflow (alu_overflow)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      done_reg     <= '0;
      result_reg   <= '0;
      zero_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      busy_reg     <= 1'b0;
      pointer_reg  <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      h_reg        <= '0;
      op_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            state_reg   <= EXEC;
            grant_reg   <= winner_oh;
            busy_reg    <= 1'b1;
            pointer_reg <= pointer_next;
            a_reg       <= a_sel;
            b_reg       <= b_sel;
            h_reg       <= h_sel;
            op_reg      <= op_sel;
          end
        end
        EXEC: begin
          state_reg    <= DONE;
          result_reg   <= alu_result;
          zero_reg     <= alu_zero;
          overflow_reg <= alu_overflow;
          done_reg     <= grant_reg;
        end
        DONE: begin
          // result/zero/overflow deliberately hold until the next capture.
          state_reg <= IDLE;
          grant_reg <= '0;
          done_reg  <= '0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= '0;
          done_reg  <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant    = grant_reg;
  assign bus.done     = done_reg;
  assign bus.result   = result_reg;
  assign bus.zero     = zero_reg;
  assign bus.overflow = overflow_reg;
  assign bus.busy     = busy_reg;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one ALU_32 instance between N requesters using round-robin arbitration and a req/grant/done handshake. The block latches the winner's operands and opcode, then drives the ALU from those registers. It registers Result/Zero/Overflow and returns them to the winner with a one-cycle done pulse. It sits between the datapath clients (e.g. main pipeline and address-generation unit) and the single ALU.

Parameters:
N, 4, number of requesters (2..8)
PW, 3, width of the round-robin pointer/index; must satisfy 2^PW >= N

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
req  input  N  per-requester operation request; held high until done seen
a_in  input  32*N  operand A, requester i at bits [32i+31:32i]
b_in  input  32*N  operand B, same packing
h_in  input  5*N  shift amount H, requester i at [5i+4:5i]
op_in  input  7*N  alu_op {Shift,Ainvert,Binvert,CarryIn,Op2,Op1,Op0}, requester i at [7i+6:7i]
grant  output  N  one-hot, owner of the ALU during EXEC and DONE
done  output  N  one-hot, one-cycle pulse: result valid for that requester
result  output  32  registered ALU Result
zero  output  1  registered ALU Zero
overflow  output  1  registered ALU Overflow
busy  output  1  high in EXEC and DONE

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-low. While reset=0 the block is held in reset.
- Reset values: state=IDLE, grant=0, done=0, result=0, zero=0, overflow=0, busy=0, pointer=0, operand regs=0.
- FSM states: IDLE, EXEC, DONE.
  - IDLE to EXEC on an edge with req!=0.
    - Winner = first asserted req index scanning pointer, pointer+1, ... mod N.
    - Winner's A/B/H/op are loaded into the operand registers.
    - grant[winner] is set.
    - pointer becomes (winner+1) mod N.
  - With req==0, IDLE holds.
  - EXEC to DONE unconditionally.
    - ALU_32 is combinational from the operand registers.
    - result/zero/overflow are captured from it.
    - done[winner] is set.
  - DONE to IDLE unconditionally. grant and done clear; result/zero/overflow hold their values until the next capture.
- Latency: request sampled at edge k, grant visible after k, done visible after k+1, cleared after k+2. Next grant no earlier than edge k+3, so at most one op per 3 cycles.
- Operand capture: operands are captured at grant. Requester inputs may change after grant without effect.
- Handshake: the requester drops req on the edge where it samples done=1. A req still high in IDLE after DONE is treated as a new request. Dropping req during EXEC/DONE does not abort; done still pulses.
- Requests arriving in EXEC/DONE wait; they are not lost as long as req is held.
- Simultaneous requests: exactly one is granted per arbitration; the others wait. No requester waits more than N-1 grants.
- Unassigned req bits when N < 2^PW: indices >= N are never granted.
- Reset mid-operation (EXEC or DONE): immediate return to reset values. No done is issued; the requester must re-request.
- Arithmetic: the block performs none itself; all results are ALU_32's. overflow is passed through for every opcode, including SLT (overflow=1 is legal there).

Decomposition:
- Shared include file holds:
  - state encodings (IDLE=2'd0, EXEC=2'd1, DONE=2'd2);
  - alu_op constants: AND 0000000, OR 0000001, ADD 0000010, SUB 0001110, SLT 0001111, NOR 0011000, NAND 0011001, MUL 0100000, SLL 1000000, LOG2 1100000.
- Sub-module rr_pick (combinational: req, pointer -> one-hot winner + index).
- Existing ALU_32 is instantiated as the datapath.

Test Plan:
- Reset: hold reset=0, then drive req=4'b1111 -> all outputs 0, grant=0, busy=0 throughout; after release, first grant goes to index 0.
- Single request: req[0], A=45, B=21, op=ADD -> grant=0001 one cycle after sampling; done=0001 on the next cycle with result=66, zero=0, overflow=0; done high exactly one cycle.
- Contention: req[0]=AND 45,21 and req[2]=SUB 45,45, both requesting at once with pointer=0 -> req[0] first (result=5); then req[2] (result=0, zero=1); grant never 0101.
- Fairness: all four requesting continuously -> grant sequence 0001, 0010, 0100, 1000, 0001; each done 3 cycles apart.
- Overflow pass-through:
  - req[1] ADD A=0x7FFFFFFF, B=1 -> result=0x80000000, overflow=1.
  - req[3] SLL B=45, H=2 -> result=180, overflow=0.
- Reset mid-op: assert reset during EXEC -> grant/busy drop immediately, no done pulse, pointer=0; after release, the held req is re-granted and completes normally.
